// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the two-client memory port arbiter.
// master = arbiter side, slave = clients plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
);
  logic [1:0]          req;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          gnt;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_perr;
  logic [ERR_W-1:0]    err_cnt;
  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W-1:0]   mem_data_in;
  logic [DATA_W:0]     mem_data_out;

  // Handshake: a client holds req/we/addr/wdata stable until it sees its one-cycle
  // gnt pulse; dropping req before gnt withdraws it. Completion is a one-cycle
  // rsp_valid pulse to the granted client, with rsp_rdata/rsp_perr valid alongside.
  modport master (
    input  req, req_we, req_addr, req_wdata, mem_data_out,
    output gnt, rsp_valid, rsp_rdata, rsp_perr, err_cnt,
    output mem_read, mem_write, mem_address, mem_data_in
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, mem_data_out,
    input  gnt, rsp_valid, rsp_rdata, rsp_perr, err_cnt,
    input  mem_read, mem_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin controller sharing one single-port parity memory between two clients;
// sequences each access, checks read parity and returns the completion to the owner.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_owner;
  logic [1:0]          r_gnt;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_perr;
  logic [ERR_W-1:0]    r_err_cnt;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [DATA_W-1:0]   r_mem_data_in;

  logic                w_winner;
  logic                w_we_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [DATA_W-1:0]   w_wdata_sel;
  logic                w_perr;
  logic [1:0]          w_owner_oh;

  // With both clients asking, the one not granted last wins; a lone request always wins.
  assign w_winner    = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_we_sel    = w_winner ? bus.req_we[1] : bus.req_we[0];
  assign w_addr_sel  = w_winner ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
  assign w_wdata_sel = w_winner ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  assign w_owner_oh  = {r_owner, ~r_owner};

  // Stored word carries even total parity; odd parity or unknown bits count as an error.
  assign w_perr = ((^bus.mem_data_out) !== 1'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_owner       <= 1'b0;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_perr    <= 1'b0;
      r_err_cnt     <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_owner       <= w_winner;
            r_last        <= w_winner;
            r_gnt         <= w_winner ? 2'b10 : 2'b01;
            r_mem_address <= w_addr_sel;
            if (w_we_sel) begin
              r_mem_write   <= 1'b1;
              r_mem_data_in <= w_wdata_sel;
              r_state       <= S_WR;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= S_RD;
            end
          end
        end
        S_WR: begin
          r_mem_write <= 1'b0;
          r_rsp_valid <= w_owner_oh;
          r_rsp_perr  <= 1'b0;
          r_state     <= S_RSP;
        end
        S_RD: begin
          r_mem_read <= 1'b0;
          r_state    <= S_CAP;
        end
        S_CAP: begin
          r_rsp_valid <= w_owner_oh;
          r_rsp_rdata <= bus.mem_data_out[DATA_W-1:0];
          r_rsp_perr  <= w_perr;
          if (w_perr && (r_err_cnt != {ERR_W{1'b1}}))
            r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
          r_state     <= S_RSP;
        end
        S_RSP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_perr    = r_rsp_perr;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a parity-memory stub
// and a behavioural reference (memory contents, round-robin order, error count).
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         tests = 0;
  int         fails = 0;
  int         mon_bad = 0;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(8), .ERR_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .ERR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Memory stub: registered read, stores {parity, data} with even total parity.
  logic [8:0] mem_arr [0:65535];
  bit         stub_en = 1'b0;
  logic [8:0] stub_word = 9'h000;

  always @(posedge clk) begin
    if (bus.mem_write) mem_arr[bus.mem_address] <= {^bus.mem_data_in, bus.mem_data_in};
    if (bus.mem_read) bus.mem_data_out <= stub_en ? stub_word : mem_arr[bus.mem_address];
  end

  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) mon_bad++;
    if ($countones(bus.gnt) > 1 || $countones(bus.rsp_valid) > 1) mon_bad++;
  end

  logic [7:0] ref_mem [int];
  int         exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic int rr_pick(input logic [1:0] reqs, input int last);
    if (reqs == 2'b11) return 1 - last;
    return reqs[1] ? 1 : 0;
  endfunction

  task automatic idle_inputs();
    bus.req       = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic txn(input int r, input bit we, input logic [15:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic pe);
    int         n;
    bit         seen;
    logic [7:0] prev;
    @(negedge clk);
    prev = bus.rsp_rdata;
    bus.req[r]            = 1'b1;
    bus.req_we[r]         = we;
    bus.req_addr[r*16 +: 16] = a;
    bus.req_wdata[r*8 +: 8]  = d;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.gnt != 2'b00);
    end
    check("gnt_seen", 32'(seen), 32'd1);
    bus.req[r] = 1'b0;
    check("gnt_owner", 32'(bus.gnt), 32'(oh(r)));
    check("mem_write", 32'(bus.mem_write), 32'(we));
    check("mem_read", 32'(bus.mem_read), 32'(!we));
    check("mem_addr", 32'(bus.mem_address), 32'(a));
    if (we) check("mem_din", 32'(bus.mem_data_in), 32'(d));
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("mem_strobe_1cyc", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        check("gnt_1cyc", 32'(bus.gnt), 32'd0);
      end
      seen = (bus.rsp_valid != 2'b00);
    end
    check("rsp_latency", 32'(n), we ? 32'd1 : 32'd2);
    check("rsp_owner", 32'(bus.rsp_valid), 32'(oh(r)));
    rd = bus.rsp_rdata;
    pe = bus.rsp_perr;
    if (we) begin
      check("wr_perr", 32'(pe), 32'd0);
      check("wr_rdata_hold", 32'(rd), 32'(prev));
    end
  endtask

  task automatic do_write(input int r, input logic [15:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic       pe;
    txn(r, 1'b1, a, d, rd, pe);
    ref_mem[int'(a)] = d;
  endtask

  task automatic do_read(input int r, input logic [15:0] a);
    logic [7:0] rd;
    logic       pe;
    txn(r, 1'b0, a, 8'h00, rd, pe);
    check("rd_data", 32'(rd), 32'(ref_mem[int'(a)]));
    check("rd_perr", 32'(pe), 32'd0);
  endtask

  initial begin
    logic [7:0]  rd;
    logic        pe;
    logic [15:0] r_addr [6];
    int          idx [6];
    int          last, w, k;
    bit          seen;

    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_perr", 32'(bus.rsp_perr), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_mem_rw", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check("rst_mem_din", 32'(bus.mem_data_in), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    do_write(0, 16'h1234, 8'hA5);
    txn(1, 1'b0, 16'h1234, 8'h00, rd, pe);
    check("readback_data", 32'(rd), 32'h0000_00A5);
    check("readback_perr", 32'(pe), 32'd0);
    check("readback_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Contention from reset: both clients hold write requests.
    @(negedge clk);
    rst_n = 1'b0;
    bus.req       = 2'b11;
    bus.req_we    = 2'b11;
    bus.req_addr  = {16'h0101, 16'h0100};
    bus.req_wdata = {8'h51, 8'h50};
    @(negedge clk);
    rst_n = 1'b1;
    last = 1;
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        w = rr_pick(2'b11, last);
        check("rr_order", 32'(bus.gnt), 32'(oh(w)));
        last = w;
        k++;
        if (k == 4) bus.req = 2'b10;
      end
    end
    check("rr_grants", 32'(k), 32'd4);
    k = 0;
    for (int c = 0; c < 40 && k < 2; c++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        w = rr_pick(2'b10, last);
        check("rr_single", 32'(bus.gnt), 32'(oh(w)));
        last = w;
        k++;
      end
    end
    check("rr_single_grants", 32'(k), 32'd2);
    idle_inputs();
    repeat (4) @(negedge clk);
    ref_mem[16'h0100] = 8'h50;
    ref_mem[16'h0101] = 8'h51;
    do_read(0, 16'h0100);
    do_read(1, 16'h0101);

    // Parity errors injected by the memory stub.
    stub_en = 1'b1;
    stub_word = 9'h1A5;
    txn(0, 1'b0, 16'h0200, 8'h00, rd, pe);
    exp_err = 1;
    check("perr_bad", 32'(pe), 32'd1);
    check("perr_bad_data", 32'(rd), 32'h0000_00A5);
    check("perr_cnt1", 32'(bus.err_cnt), 32'(exp_err));
    stub_word = 9'h0A5;
    txn(1, 1'b0, 16'h0200, 8'h00, rd, pe);
    check("perr_good", 32'(pe), 32'd0);
    check("perr_cnt_hold", 32'(bus.err_cnt), 32'(exp_err));
    stub_word = 9'h1A5;
    for (int i = 0; i < 300; i++) begin
      txn(i % 2, 1'b0, 16'h0300, 8'h00, rd, pe);
      exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
      check("perr_sat_flag", 32'(pe), 32'd1);
      check("perr_sat_cnt", 32'(bus.err_cnt), 32'(exp_err));
    end
    check("perr_saturated", 32'(bus.err_cnt), 32'h0000_00FF);
    stub_en = 1'b0;

    // Reset in the middle of a read.
    @(negedge clk);
    bus.req[0] = 1'b1;
    bus.req_we[0] = 1'b0;
    bus.req_addr[15:0] = 16'h1234;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.gnt != 2'b00);
    end
    check("midrst_gnt", 32'(seen), 32'd1);
    idle_inputs();
    check("midrst_read_hi", 32'(bus.mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_read_lo", 32'(bus.mem_read), 32'd0);
    check("midrst_err_clr", 32'(bus.err_cnt), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    exp_err = 0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) seen = 1'b1;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    do_write(0, 16'h4321, 8'h3C);
    do_read(1, 16'h4321);

    // Random writes from alternating clients, then reads in shuffled order.
    for (int i = 0; i < 6; i++) begin
      r_addr[i] = 16'(($urandom_range(0, 4095) << 4) | i);
      idx[i] = i;
      do_write(i % 2, r_addr[i], 8'($urandom_range(0, 255)));
    end
    for (int i = 5; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = idx[i];
      idx[i] = idx[j];
      idx[j] = t;
    end
    for (int i = 0; i < 6; i++) do_read(int'($urandom_range(0, 1)), r_addr[idx[i]]);
    check("rand_err_cnt", 32'(bus.err_cnt), 32'(exp_err));

    repeat (2) @(negedge clk);
    check("monitor_clean", 32'(mon_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
